// File: rtl/reg_bus_pkg.sv
// Shared definitions for the 8-bit display register bus (writer and receiver).
// Address map, field count, sequencing states and small helper functions.
package reg_bus_pkg;

    localparam int NUM_FIELDS = 6;

    localparam logic [2:0] ADDR_SPEED    = 3'd0;
    localparam logic [2:0] ADDR_RTD      = 3'd1;
    localparam logic [2:0] ADDR_CAR_BAT  = 3'd2;
    localparam logic [2:0] ADDR_DISP_BAT = 3'd3;
    localparam logic [2:0] ADDR_GPS      = 3'd4;
    localparam logic [2:0] ADDR_ERR      = 3'd5;
    localparam logic [2:0] ADDR_CSUM     = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        CSUM,
        FIN
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [2:0] lowest_idx(input logic [NUM_FIELDS-1:0] m);
        lowest_idx = 3'd0;
        for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = 3'(i);
        end
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bus_cycle_timer.sv
// Sequences one register write cycle: SETUP -> STROBE -> HOLD with a shared
// down-counter. 'go' starts a cycle (also back-to-back on 'last'); 'last' flags the final HOLD cycle.
module bus_cycle_timer
    import reg_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    output logic write,
    output logic last
);

    localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC)) + 1;

    state_t           phase_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             write_reg;

    assign last  = (phase_reg == HOLD) && (cnt_reg == '0);
    assign write = write_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_reg <= IDLE;
            cnt_reg   <= '0;
            write_reg <= 1'b0;
        end else if (go) begin
            phase_reg <= SETUP;
            cnt_reg   <= CNT_W'(SETUP_CYC - 1);
            write_reg <= 1'b0;
        end else begin
            case (phase_reg)
                SETUP: begin
                    if (cnt_reg == '0) begin
                        phase_reg <= STROBE;
                        cnt_reg   <= CNT_W'(STROBE_CYC - 1);
                        write_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt_reg == '0) begin
                        phase_reg <= HOLD;
                        cnt_reg   <= CNT_W'(HOLD_CYC - 1);
                        write_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_reg == '0) phase_reg <= IDLE;
                    else               cnt_reg   <= cnt_reg - 1'b1;
                end
                default: phase_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/reg_bus_writer.sv
// Snapshots a telemetry frame and replays it as timed writes on the display register bus.
// Optional checksum write to address 7 is enabled by defining REG_BUS_CHECKSUM_EN.
module reg_bus_writer
    import reg_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       start,
    input  logic [5:0] field_mask,
    input  logic [7:0] speed,
    input  logic       ready_to_drive,
    input  logic [7:0] car_battery,
    input  logic [7:0] disp_battery,
    input  logic [1:0] gps_status,
    input  logic [7:0] err_code,
    output logic [7:0] port_out,
    output logic [2:0] addr_out,
    output logic       write_out,
    output logic       busy,
    output logic       done
);

`ifdef REG_BUS_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
    logic [7:0] csum_reg;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic [NUM_FIELDS-1:0][7:0] fields_in;
    logic [NUM_FIELDS-1:0][7:0] fields_reg;
    logic [NUM_FIELDS-1:0]      remain_reg;
    state_t                     state_reg;
    logic [2:0]                 addr_reg;
    logic [7:0]                 port_reg;
    logic                       busy_reg;
    logic                       done_reg;
    logic                       go;
    logic                       last;
    logic                       strobe;
    logic [2:0]                 first_idx;
    logic [2:0]                 next_idx;

    assign fields_in[ADDR_SPEED]    = speed;
    assign fields_in[ADDR_RTD]      = {7'b0, ready_to_drive};
    assign fields_in[ADDR_CAR_BAT]  = car_battery;
    assign fields_in[ADDR_DISP_BAT] = disp_battery;
    assign fields_in[ADDR_GPS]      = {6'b0, gps_status};
    assign fields_in[ADDR_ERR]      = err_code;

    assign first_idx = lowest_idx(field_mask);
    assign next_idx  = lowest_idx(remain_reg);

    // SETUP covers a whole field cycle here; its sub-phases are tracked by the timer.
    always_comb begin
        go = 1'b0;
        case (state_reg)
            IDLE:    go = start && ((field_mask != '0) || CSUM_ON);
            SETUP:   go = last && ((remain_reg != '0) || CSUM_ON);
            default: go = 1'b0;
        endcase
    end

    bus_cycle_timer #(
        .SETUP_CYC  (SETUP_CYC),
        .STROBE_CYC (STROBE_CYC),
        .HOLD_CYC   (HOLD_CYC)
    ) u_timer (
        .clk   (Clk),
        .rst_n (Reset_n),
        .go    (go),
        .write (strobe),
        .last  (last)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg  <= IDLE;
            fields_reg <= '0;
            remain_reg <= '0;
            addr_reg   <= '0;
            port_reg   <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef REG_BUS_CHECKSUM_EN
            csum_reg   <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        fields_reg <= fields_in;
                        if (field_mask != '0) begin
                            state_reg  <= SETUP;
                            busy_reg   <= 1'b1;
                            addr_reg   <= first_idx;
                            port_reg   <= fields_in[first_idx];
                            remain_reg <= field_mask & (field_mask - 1'b1);
`ifdef REG_BUS_CHECKSUM_EN
                            csum_reg   <= fields_in[first_idx];
`endif
                        end else begin
                            remain_reg <= '0;
`ifdef REG_BUS_CHECKSUM_EN
                            state_reg  <= CSUM;
                            busy_reg   <= 1'b1;
                            addr_reg   <= ADDR_CSUM;
                            port_reg   <= 8'h00;
`else
                            state_reg  <= FIN;
                            done_reg   <= 1'b1;
`endif
                        end
                    end
                end
                SETUP: begin
                    if (last) begin
                        if (remain_reg != '0) begin
                            addr_reg   <= next_idx;
                            port_reg   <= fields_reg[next_idx];
                            remain_reg <= remain_reg & (remain_reg - 1'b1);
`ifdef REG_BUS_CHECKSUM_EN
                            csum_reg   <= csum_reg ^ fields_reg[next_idx];
`endif
                        end else begin
`ifdef REG_BUS_CHECKSUM_EN
                            state_reg <= CSUM;
                            addr_reg  <= ADDR_CSUM;
                            port_reg  <= csum_reg;
`else
                            state_reg <= FIN;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            addr_reg  <= '0;
                            port_reg  <= '0;
`endif
                        end
                    end
                end
`ifdef REG_BUS_CHECKSUM_EN
                CSUM: begin
                    if (last) begin
                        state_reg <= FIN;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        addr_reg  <= '0;
                        port_reg  <= '0;
                    end
                end
`endif
                FIN:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign port_out  = port_reg;
    assign addr_out  = addr_reg;
    assign write_out = strobe;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_reg_bus_writer.sv
// Bench for reg_bus_writer: directed and random frames checked cycle by cycle
// against a timeline model built from the bus write rules.
module tb_reg_bus_writer;

    localparam int SETUP_CYC  = 2;
    localparam int STROBE_CYC = 3;
    localparam int HOLD_CYC   = 1;
    localparam int PER        = SETUP_CYC + STROBE_CYC + HOLD_CYC;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       start;
    logic [5:0] field_mask;
    logic [7:0] speed;
    logic       ready_to_drive;
    logic [7:0] car_battery;
    logic [7:0] disp_battery;
    logic [1:0] gps_status;
    logic [7:0] err_code;
    logic [7:0] port_out;
    logic [2:0] addr_out;
    logic       write_out;
    logic       busy;
    logic       done;

    int vectors    = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    reg_bus_writer #(
        .SETUP_CYC  (SETUP_CYC),
        .STROBE_CYC (STROBE_CYC),
        .HOLD_CYC   (HOLD_CYC)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .start          (start),
        .field_mask     (field_mask),
        .speed          (speed),
        .ready_to_drive (ready_to_drive),
        .car_battery    (car_battery),
        .disp_battery   (disp_battery),
        .gps_status     (gps_status),
        .err_code       (err_code),
        .port_out       (port_out),
        .addr_out       (addr_out),
        .write_out      (write_out),
        .busy           (busy),
        .done           (done)
    );

    // Observed bus state packed as {write, addr, port, busy, done}.
    function automatic logic [31:0] observed();
        return {18'b0, write_out, addr_out, port_out, busy, done};
    endfunction

    function automatic logic [31:0] pack(input logic w, input logic [2:0] a,
                                         input logic [7:0] d, input logic b, input logic dn);
        return {18'b0, w, a, d, b, dn};
    endfunction

    task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed {w,a,d,b,dn}=%h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [7:0] s, input logic r, input logic [7:0] cb,
                              input logic [7:0] db, input logic [1:0] g, input logic [7:0] e);
        speed = s; ready_to_drive = r; car_battery = cb;
        disp_battery = db; gps_status = g; err_code = e;
    endtask

    // Called at a negedge. poke_at: cycle at which speed is altered and start re-pulsed.
    // abort_at: cycle after which reset is applied for one edge.
    task automatic run_frame(input string tag, input logic [5:0] m, input int poke_at, input int abort_at);
        logic [2:0] ea[$];
        logic [7:0] ed[$];
        logic [7:0] fv[6];
        logic [7:0] x;
        int n, k, p;
        logic w;
        fv[0] = speed; fv[1] = {7'b0, ready_to_drive}; fv[2] = car_battery;
        fv[3] = disp_battery; fv[4] = {6'b0, gps_status}; fv[5] = err_code;
        x = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (m[i]) begin
                ea.push_back(3'(i));
                ed.push_back(fv[i]);
                x = x ^ fv[i];
            end
        end
`ifdef REG_BUS_CHECKSUM_EN
        ea.push_back(3'd7);
        ed.push_back(x);
`endif
        n = ea.size();
        field_mask = m;
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        for (int c = 0; c <= n * PER; c++) begin
            @(negedge Clk);
            if (c < n * PER) begin
                k = c / PER;
                p = c % PER;
                w = (p >= SETUP_CYC) && (p < SETUP_CYC + STROBE_CYC);
                check(tag, c, observed(), pack(w, ea[k], ed[k], 1'b1, 1'b0));
            end else begin
                check(tag, c, observed(), pack(1'b0, 3'd0, 8'd0, 1'b0, 1'b1));
            end
            if (c == abort_at) begin
                Reset_n = 1'b0;
                @(negedge Clk);
                check({tag, "_rst"}, c + 1, observed(), pack(1'b0, 3'd0, 8'd0, 1'b0, 1'b0));
                Reset_n = 1'b1;
                return;
            end
            if (c == poke_at) begin
                speed = 8'hFF;
                start = 1'b1;
                @(posedge Clk); #1;
                start = 1'b0;
            end
        end
        // No queued or restarted frame afterwards.
        for (int c = 1; c <= 3; c++) begin
            @(negedge Clk);
            check({tag, "_idle"}, n * PER + c, observed(), pack(1'b0, 3'd0, 8'd0, 1'b0, 1'b0));
        end
        $display("frame %s mask=%b writes=%0d checked", tag, m, n);
    endtask

    initial begin
        Reset_n = 1'b0;
        start = 1'b0;
        field_mask = 6'h00;
        set_fields(8'h00, 1'b0, 8'h00, 8'h00, 2'd0, 8'h00);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset", 0, observed(), pack(1'b0, 3'd0, 8'd0, 1'b0, 1'b0));
        Reset_n = 1'b1;
        @(negedge Clk);
        check("reset_idle", 1, observed(), pack(1'b0, 3'd0, 8'd0, 1'b0, 1'b0));

        set_fields(8'h2A, 1'b1, 8'h64, 8'h50, 2'd2, 8'h07);
        run_frame("full", 6'h3F, -1, -1);

        set_fields(8'h2A, 1'b1, 8'h64, 8'h50, 2'd2, 8'h07);
        run_frame("sparse", 6'b100101, -1, -1);

        // Addr-1 strobe occupies cycles PER+SETUP_CYC .. PER+SETUP_CYC+STROBE_CYC-1.
        set_fields(8'h2A, 1'b1, 8'h64, 8'h50, 2'd2, 8'h07);
        run_frame("snapshot", 6'h3F, PER + SETUP_CYC, -1);

        set_fields(8'h2A, 1'b1, 8'h64, 8'h50, 2'd2, 8'h07);
        run_frame("abort", 6'h3F, -1, SETUP_CYC + 1);
        set_fields(8'h2A, 1'b1, 8'h64, 8'h50, 2'd2, 8'h07);
        run_frame("after_abort", 6'h3F, -1, -1);

        set_fields(8'h11, 1'b1, 8'h22, 8'h33, 2'd3, 8'h44);
        run_frame("mask_zero", 6'h00, -1, -1);

        for (int r = 0; r < 20; r++) begin
            set_fields(8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                       2'($urandom), 8'($urandom));
            run_frame($sformatf("rand%0d", r), 6'($urandom), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
